// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control path:
// ALU ops, opcodes, sequencer states, instruction classes and datapath mux selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_ROL = 4'd10
    } alu_ops_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE   = 4'd0,
        C_RTYPE  = 4'd1,
        C_IALU   = 4'd2,
        C_LOAD   = 4'd3,
        C_STORE  = 4'd4,
        C_BRANCH = 4'd5,
        C_JAL    = 4'd6,
        C_JALR   = 4'd7,
        C_LUI    = 4'd8,
        C_AUIPC  = 4'd9
    } insn_class_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RS2 = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Unified instruction/data memory port between the sequencer (master) and the bus (slave).
interface rv_multicycle_ctrl_if;
    // mem_req is raised with mem_we/mem_size/addr_sel stable and held until mem_ack;
    // the request completes on the clock edge where mem_req and mem_ack are both 1.
    logic mem_req;
    logic mem_we;
    logic mem_size;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_size,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_size,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/rv_insn_class.sv
// Combinational instruction classifier: maps ir to class, ALU op, access size and legality.
module rv_insn_class
    import rv_ctrl_pkg::*;
(
    input  logic [31:0]  ir,
    output insn_class_t  cls,
    output alu_ops_t     alu_op,
    output logic         mem_size,
    output logic         legal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ir_bits;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

    always_comb begin
        cls      = C_NONE;
        alu_op   = ALU_NOP;
        mem_size = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OP_REG: begin
                cls   = C_RTYPE;
                legal = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_op = ALU_ADD;
                    10'b0100000_000: alu_op = ALU_SUB;
                    10'b0000000_001: alu_op = ALU_SLL;
                    10'b0000000_100: alu_op = ALU_XOR;
                    10'b0000000_101: alu_op = ALU_SRL;
                    10'b0100000_101: alu_op = ALU_SRA;
                    10'b0000000_110: alu_op = ALU_OR;
                    10'b0000000_111: alu_op = ALU_AND;
                    default:         legal  = 1'b0;
                endcase
            end
            OP_IMM: begin
                cls   = C_IALU;
                legal = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        if (funct7 == 7'b0000000) alu_op = ALU_SLL;
                        else                      legal  = 1'b0;
                    end
                    // funct7[5] picks arithmetic over logical right shift
                    3'b101: begin
                        if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                        else                           legal  = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                cls      = (opcode == OP_LOAD) ? C_LOAD : C_STORE;
                alu_op   = ALU_ADD;
                mem_size = (funct3 == 3'b010);
                legal    = (funct3 == 3'b000) || (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                cls    = C_BRANCH;
                alu_op = ALU_SUB;
                legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OP_JAL: begin
                cls    = C_JAL;
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
            OP_JALR: begin
                cls    = C_JALR;
                alu_op = ALU_ADD;
                legal  = (funct3 == 3'b000);
            end
            OP_LUI: begin
                cls    = C_LUI;
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
            OP_AUIPC: begin
                cls    = C_AUIPC;
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer: steps the shared datapath through fetch/decode/exec/mem/wb,
// with a req/ack memory handshake guarded by a timeout that parks the core in HALT.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 ir,
    input  logic                        alu_zero,
    rv_multicycle_ctrl_if.master        bus,
    output logic                        ir_we,
    output logic                        pc_we,
    output logic [1:0]                  pc_src,
    output logic                        reg_we,
    output logic [1:0]                  wb_sel,
    output logic [1:0]                  alu_a_sel,
    output logic [1:0]                  alu_b_sel,
    output alu_ops_t                    alu_op,
    output logic                        illegal,
    output logic                        halted,
    output state_t                      dbg_state
);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  tmo_cnt;
    insn_class_t cls;
    alu_ops_t    cls_alu_op;
    logic        cls_mem_size;
    logic        cls_legal;
    logic        tmo_hit;

    rv_insn_class u_class (
        .ir       (ir),
        .cls      (cls),
        .alu_op   (cls_alu_op),
        .mem_size (cls_mem_size),
        .legal    (cls_legal)
    );

    assign dbg_state = state;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // Counter is zero whenever no request is pending, so it starts clean on FETCH/MEM entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tmo_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (!bus.mem_req || bus.mem_ack) tmo_cnt <= 8'd0;
            else                             tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next   = state;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_size = 1'b0;
        bus.addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        alu_op       = ALU_NOP;
        illegal      = 1'b0;
        halted       = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_size = 1'b1;
                if (bus.mem_ack) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (cls_legal) begin
                    state_next = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op     = cls_alu_op;
                state_next = S_WB;
                case (cls)
                    C_IALU, C_JALR: alu_b_sel = B_IMM;
                    C_LOAD, C_STORE: begin
                        alu_b_sel  = B_IMM;
                        state_next = S_MEM;
                    end
                    C_LUI: begin
                        alu_a_sel = A_ZERO;
                        alu_b_sel = B_IMM;
                    end
                    C_AUIPC: begin
                        alu_a_sel = A_PC;
                        alu_b_sel = B_IMM;
                    end
                    // funct3[0] distinguishes BNE from BEQ
                    C_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_src     = (alu_zero ^ ir[12]) ? PC_IMM : PC_PLUS4;
                        state_next = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (cls == C_STORE);
                bus.mem_size = cls_mem_size;
                alu_op       = cls_alu_op;
                alu_b_sel    = B_IMM;
                if (bus.mem_ack) begin
                    if (cls == C_STORE) begin
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                state_next = S_FETCH;
                case (cls)
                    C_LOAD: wb_sel = WB_MEM;
                    C_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_IMM;
                    end
                    // the jump target comes straight off the ALU, so its operands stay up
                    C_JALR: begin
                        wb_sel    = WB_PC4;
                        pc_src    = PC_ALU;
                        alu_op    = cls_alu_op;
                        alu_b_sel = B_IMM;
                    end
                    default: ;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset core. It drives the shared datapath (PC, IR, register file, ALU, single memory port) one step per state.
- Sequence per instruction: fetch, decode, execute, memory, writeback.
- Replaces the single-cycle decode strobes with timed per-state strobes and a req/ack memory handshake with timeout.
- Sits between the datapath and the unified instruction/data bus.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before entering HALT (range 1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents (valid from DECODE onward)
- alu_zero  in  1  ALU result == 0
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=store
- mem_size  out  1  1=word, 0=byte
- addr_sel  out  1  0=PC, 1=ALU result
- ir_we  out  1  latch memory read data into IR
- pc_we  out  1  update PC
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result (datapath clears bit0)
- reg_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=memory, 2=PC+4
- alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
- alu_b_sel  out  2  0=rs2, 1=imm
- alu_op  out  4  shared ALU op encoding
- illegal  out  1  one-cycle pulse on unsupported instruction
- halted  out  1  sticky, set by bus timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are combinational from state and ir. Every output not named in a state is 0.
- Reset has priority over everything, including mid-handshake: state goes to IDLE, timeout counter to 0, halted to 0. In IDLE all outputs are 0, and the next state is FETCH.
- FETCH:
  - mem_req=1, addr_sel=0, mem_size=1.
  - On mem_ack: ir_we=1, go to DECODE. mem_ack may arrive in the first FETCH cycle.
- DECODE:
  - One cycle, no strobes. Supported opcodes go to EXEC.
  - Unsupported opcode or funct: illegal=1, pc_we=1, pc_src=0, go to FETCH.
- Supported set and ALU op:
  - R-type: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA.
  - I-type ALU: ADDI/ANDI/ORI/XORI/SLLI/SRLI/SRAI. funct7[5] selects SRA over SRL.
  - LB/LW, SB/SW: ADD, mem_size = (funct3==010).
  - BEQ/BNE: SUB.
  - JAL, JALR, LUI, AUIPC: ADD.
- EXEC (alu_op valid all cycle):
  - R-type: a=rs1, b=rs2, then WB.
  - I-ALU, load, store, JALR: a=rs1, b=imm. I-ALU and JALR go to WB; load and store go to MEM.
  - LUI: a=zero, b=imm. AUIPC: a=PC, b=imm. Both go to WB.
  - JAL: goes to WB, no ALU use.
  - Branch: a=rs1, b=rs2. taken = alu_zero XOR funct3[0]. pc_we=1, pc_src = taken ? 1 : 0, go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we = store, mem_size per funct3. ALU operands stay as in EXEC.
  - On ack: a load goes to WB. A store asserts pc_we=1, pc_src=0 and goes to FETCH.
- WB:
  - reg_we=1. wb_sel: 1 for load, 2 for JAL/JALR, else 0.
  - pc_we=1, pc_src: 1 for JAL, 2 for JALR (ALU operands held as EXEC), else 0.
  - Go to FETCH.
- Timeout:
  - Counter clears on entering FETCH or MEM and on ack; it increments on each cycle with mem_req=1 and mem_ack=0.
  - Reaching MEM_TIMEOUT moves to HALT. No pc_we is issued.
  - HALT: halted=1, all strobes 0, exit only by reset.
- Latency with zero-wait memory:
  - branch 3 cycles
  - R/I/LUI/AUIPC/JAL/JALR/store 4 cycles
  - load 5 cycles
  - each memory wait cycle adds 1
- PC and IR are unchanged between FETCH completion and the instruction's final pc_we. PC+4 always refers to the current instruction.

Decomposition:
- Package rv_ctrl_pkg holds:
  - alu_ops_t (ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6, SLL=7, SRL=8, SRA=9, ROL=10)
  - opcode localparams
  - state enum
  - pc_src, wb_sel and alu-select encodings
- Sub-module rv_insn_class (combinational) maps ir to {class, alu_op, mem_size, legal}. The FSM is in the top module.

Test Plan:
- ir=0x002081B3 (ADD x3,x1,x2), ack in the first cycle → FETCH, DECODE, EXEC (alu_op=1, a_sel=0, b_sel=0), WB (reg_we=1, wb_sel=0, pc_we=1, pc_src=0); 4 cycles total.
- ir=0x0080A283 (LW x5,8(x1)), mem_ack in MEM delayed 3 cycles → MEM holds mem_req=1, addr_sel=1, mem_we=0, mem_size=1 for 4 cycles; WB wb_sel=1; 8 cycles total.
- ir=0x00208463 (BEQ +8): alu_zero=1 → EXEC pc_we=1, pc_src=1. alu_zero=0 → pc_src=0. Both 3 cycles, reg_we never 1.
- ir=0x0050A223 (SW x5,4(x1)) → MEM mem_we=1, mem_size=1; pc_we=1, pc_src=0 on ack; reg_we never 1.
- ir=0x00000000 → illegal=1 for one cycle in DECODE with pc_we=1, pc_src=0; next state FETCH.
- mem_ack held 0 in FETCH with MEM_TIMEOUT=16 → HALT after 16 cycles, halted=1, mem_req=0. Then reset=1 for one cycle → IDLE, halted=0, then FETCH.
